// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and parity modes.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle-high level.
module uart_sync2 (
    input  logic clk,
    input  logic reset_p,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: mid-bit sampling FSM with optional parity, 1-2 stop bits and a
// single-entry output holding register with overrun reporting.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 13021,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset_p,
    input  logic                 RX,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    import uart_pkg::*;

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_flag_q, par_flag_d;
    logic                 frm_flag_q, frm_flag_d;
    logic                 rx_prev_q, rx_prev_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    logic rx_s;
    logic sample;
    logic done;
    logic frm_final;

    uart_sync2 u_sync (
        .clk     (clk),
        .reset_p (reset_p),
        .d       (RX),
        .q       (rx_s)
    );

    function automatic logic parity_bad(input logic [DATA_BITS-1:0] data, input logic pbit);
        logic x;
        x = (^data) ^ pbit;
        return (PARITY == PAR_ODD) ? ~x : x;
    endfunction

    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_flag_d   = par_flag_q;
        frm_flag_d   = frm_flag_q;
        rx_prev_d    = rx_s;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
        done         = 1'b0;
        frm_final    = frm_flag_q;
        sample       = (clk_cnt_q == CNT_FULL);

        case (state_q)
            ST_IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (rx_prev_q && !rx_s) begin
                    state_d    = ST_START;
                    par_flag_d = 1'b0;
                    frm_flag_d = 1'b0;
                end
            end
            ST_START: begin
                if (clk_cnt_q == CNT_HALF) begin
                    clk_cnt_d = '0;
                    state_d   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (sample) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            ST_PARITY: begin
                if (sample) begin
                    clk_cnt_d  = '0;
                    par_flag_d = parity_bad(shift_q, rx_s);
                    state_d    = ST_STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (sample) begin
                    clk_cnt_d  = '0;
                    frm_final  = frm_flag_q | ~rx_s;
                    frm_flag_d = frm_final;
                    if (bit_cnt_q == LAST_STOP) begin
                        // Back to IDLE immediately so a start edge on the next cycle is seen.
                        done      = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shift_q;
                parity_err_d = par_flag_q;
                frame_err_d  = frm_final;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q      <= ST_IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_flag_q   <= 1'b0;
            frm_flag_q   <= 1'b0;
            rx_prev_q    <= 1'b1;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_flag_q   <= par_flag_d;
            frm_flag_q   <= frm_flag_d;
            rx_prev_q    <= rx_prev_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: an 8N1 instance and an 8E1 instance, 16 clocks per bit.
module tb_uart_rx_core;

    localparam int CPB = 16;

    logic       clk;
    logic       reset_p;
    logic       rx_a, rx_b;
    logic       rx_ready_a, rx_ready_b;
    logic [7:0] rx_data_a, rx_data_b;
    logic       rx_valid_a, rx_valid_b;
    logic       parity_err_a, parity_err_b;
    logic       frame_err_a, frame_err_b;
    logic       overrun_a, overrun_b;
    logic       busy_a, busy_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Monitor state, updated only by the monitor process.
    int         rise_a = 0, rise_b = 0, ovr_a = 0, busy_cyc_a = 0;
    logic       vprev_a = 1'b0, vprev_b = 1'b0;
    logic [7:0] cap_data_a = '0, cap_data_b = '0;
    logic       cap_perr_a = 1'b0, cap_ferr_a = 1'b0;
    logic       cap_perr_b = 1'b0, cap_ferr_b = 1'b0;

    uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk        (clk),
        .reset_p    (reset_p),
        .RX         (rx_a),
        .rx_ready   (rx_ready_a),
        .rx_data    (rx_data_a),
        .rx_valid   (rx_valid_a),
        .parity_err (parity_err_a),
        .frame_err  (frame_err_a),
        .overrun    (overrun_a),
        .busy       (busy_a)
    );

    uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
        .clk        (clk),
        .reset_p    (reset_p),
        .RX         (rx_b),
        .rx_ready   (rx_ready_b),
        .rx_data    (rx_data_b),
        .rx_valid   (rx_valid_b),
        .parity_err (parity_err_b),
        .frame_err  (frame_err_b),
        .overrun    (overrun_b),
        .busy       (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        vprev_a <= rx_valid_a;
        vprev_b <= rx_valid_b;
        if (rx_valid_a && !vprev_a) begin
            rise_a     <= rise_a + 1;
            cap_data_a <= rx_data_a;
            cap_perr_a <= parity_err_a;
            cap_ferr_a <= frame_err_a;
        end
        if (rx_valid_b && !vprev_b) begin
            rise_b     <= rise_b + 1;
            cap_data_b <= rx_data_b;
            cap_perr_b <= parity_err_b;
            cap_ferr_b <= frame_err_b;
        end
        if (overrun_a) ovr_a <= ovr_a + 1;
        if (busy_a) busy_cyc_a <= busy_cyc_a + 1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // Called at a negedge; holds the line level for one bit time.
    task automatic drive_bit(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
        repeat (CPB) @(negedge clk);
    endtask

    // par_bit < 0 means no parity bit is sent.
    task automatic send_frame(input bit sel, input logic [7:0] d, input int par_bit, input logic stopv);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (par_bit >= 0) drive_bit(sel, par_bit[0]);
        drive_bit(sel, stopv);
        drive_bit(sel, 1'b1);
        drive_bit(sel, 1'b1);
    endtask

    task automatic test_reset();
        reset_p = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (rx_valid_a !== 1'b0) begin n_bad++; $display("FAIL reset_valid_a: got %b want 0", rx_valid_a); end
        n_cmp++; if (rx_data_a !== 8'h00) begin n_bad++; $display("FAIL reset_data_a: got %h want 00", rx_data_a); end
        n_cmp++; if (parity_err_a !== 1'b0) begin n_bad++; $display("FAIL reset_perr_a: got %b want 0", parity_err_a); end
        n_cmp++; if (frame_err_a !== 1'b0) begin n_bad++; $display("FAIL reset_ferr_a: got %b want 0", frame_err_a); end
        n_cmp++; if (overrun_a !== 1'b0) begin n_bad++; $display("FAIL reset_overrun_a: got %b want 0", overrun_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
        n_cmp++; if (rx_valid_b !== 1'b0) begin n_bad++; $display("FAIL reset_valid_b: got %b want 0", rx_valid_b); end
        reset_p = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        int r0;
        rx_ready_a = 1'b1;
        r0 = rise_a;
        send_frame(1'b0, 8'h30, -1, 1'b1);
        n_cmp++; if (rise_a - r0 !== 1) begin n_bad++; $display("FAIL basic_pulses: got %0d want 1", rise_a - r0); end
        n_cmp++; if (cap_data_a !== 8'h30) begin n_bad++; $display("FAIL basic_data: got %h want 30", cap_data_a); end
        n_cmp++; if (cap_perr_a !== 1'b0) begin n_bad++; $display("FAIL basic_perr: got %b want 0", cap_perr_a); end
        n_cmp++; if (cap_ferr_a !== 1'b0) begin n_bad++; $display("FAIL basic_ferr: got %b want 0", cap_ferr_a); end
        n_cmp++; if (rx_valid_a !== 1'b0) begin n_bad++; $display("FAIL basic_valid_cleared: got %b want 0", rx_valid_a); end
    endtask

    task automatic test_parity();
        int r0;
        rx_ready_b = 1'b1;
        r0 = rise_b;
        // 0x31 has three ones, so even parity needs a 1; sending 0 is wrong.
        send_frame(1'b1, 8'h31, 0, 1'b1);
        n_cmp++; if (cap_data_b !== 8'h31) begin n_bad++; $display("FAIL parity_bad_data: got %h want 31", cap_data_b); end
        n_cmp++; if (cap_perr_b !== 1'b1) begin n_bad++; $display("FAIL parity_bad_flag: got %b want 1", cap_perr_b); end
        send_frame(1'b1, 8'h31, 1, 1'b1);
        n_cmp++; if (cap_perr_b !== 1'b0) begin n_bad++; $display("FAIL parity_good_flag: got %b want 0", cap_perr_b); end
        n_cmp++; if (cap_ferr_b !== 1'b0) begin n_bad++; $display("FAIL parity_good_ferr: got %b want 0", cap_ferr_b); end
        n_cmp++; if (rise_b - r0 !== 2) begin n_bad++; $display("FAIL parity_pulses: got %0d want 2", rise_b - r0); end
    endtask

    task automatic test_glitch();
        int r0, b0;
        r0 = rise_a;
        b0 = busy_cyc_a;
        rx_a = 1'b0;
        repeat (5) @(negedge clk);
        rx_a = 1'b1;
        repeat (30) @(negedge clk);
        n_cmp++; if (busy_cyc_a - b0 <= 0) begin n_bad++; $display("FAIL glitch_busy_seen: got %0d cycles want >0", busy_cyc_a - b0); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL glitch_back_idle: busy got %b want 0", busy_a); end
        n_cmp++; if (rise_a - r0 !== 0) begin n_bad++; $display("FAIL glitch_no_valid: got %0d pulses want 0", rise_a - r0); end
    endtask

    task automatic test_frame_err();
        send_frame(1'b0, 8'h35, -1, 1'b0);
        n_cmp++; if (cap_data_a !== 8'h35) begin n_bad++; $display("FAIL ferr_data: got %h want 35", cap_data_a); end
        n_cmp++; if (cap_ferr_a !== 1'b1) begin n_bad++; $display("FAIL ferr_flag: got %b want 1", cap_ferr_a); end
        send_frame(1'b0, 8'h36, -1, 1'b1);
        n_cmp++; if (cap_data_a !== 8'h36) begin n_bad++; $display("FAIL ferr_next_data: got %h want 36", cap_data_a); end
        n_cmp++; if (cap_ferr_a !== 1'b0) begin n_bad++; $display("FAIL ferr_next_flag: got %b want 0", cap_ferr_a); end
    endtask

    task automatic test_overrun();
        int r0, o0;
        rx_ready_a = 1'b0;
        r0 = rise_a;
        o0 = ovr_a;
        send_frame(1'b0, 8'h32, -1, 1'b1);
        send_frame(1'b0, 8'h33, -1, 1'b1);
        n_cmp++; if (rx_valid_a !== 1'b1) begin n_bad++; $display("FAIL ovr_valid_held: got %b want 1", rx_valid_a); end
        n_cmp++; if (rx_data_a !== 8'h32) begin n_bad++; $display("FAIL ovr_data_held: got %h want 32", rx_data_a); end
        n_cmp++; if (ovr_a - o0 !== 1) begin n_bad++; $display("FAIL ovr_pulses: got %0d want 1", ovr_a - o0); end
        n_cmp++; if (rise_a - r0 !== 1) begin n_bad++; $display("FAIL ovr_valid_rises: got %0d want 1", rise_a - r0); end
        rx_ready_a = 1'b1;
        @(negedge clk);
        n_cmp++; if (rx_valid_a !== 1'b0) begin n_bad++; $display("FAIL ovr_valid_drop: got %b want 0", rx_valid_a); end
        n_cmp++; if (overrun_a !== 1'b0) begin n_bad++; $display("FAIL ovr_pulse_len: got %b want 0", overrun_a); end
    endtask

    task automatic test_reset_midframe();
        int r0;
        logic [7:0] junk;
        junk = 8'hA5;
        rx_ready_a = 1'b1;
        r0 = rise_a;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, junk[i]);
        rx_a = junk[4];
        repeat (10) @(negedge clk);
        reset_p = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b want 0", busy_a); end
        rx_a = 1'b1;
        reset_p = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        n_cmp++; if (rise_a - r0 !== 0) begin n_bad++; $display("FAIL midreset_no_partial: got %0d pulses want 0", rise_a - r0); end
        send_frame(1'b0, 8'h34, -1, 1'b1);
        n_cmp++; if (rise_a - r0 !== 1) begin n_bad++; $display("FAIL midreset_pulses: got %0d want 1", rise_a - r0); end
        n_cmp++; if (cap_data_a !== 8'h34) begin n_bad++; $display("FAIL midreset_data: got %h want 34", cap_data_a); end
    endtask

    initial begin
        reset_p    = 1'b1;
        rx_a       = 1'b1;
        rx_b       = 1'b1;
        rx_ready_a = 1'b0;
        rx_ready_b = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter CLKS_PER_BIT, default 13021, clk cycles per bit (125 MHz / 9600 baud); legal range 8..65535.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 clk  in  1  the single clock for the block.
REQ-006 reset_p  in  1  reset; asynchronous, active-high.
REQ-007 RX  in  1  asynchronous serial line; idles high.
REQ-008 rx_ready  in  1  consumer accepts the held frame when rx_ready and rx_valid are both high.
REQ-009 rx_data  out  DATA_BITS  received data word.
REQ-010 rx_valid  out  1  high while rx_data holds an unconsumed frame.
REQ-011 parity_err  out  1  parity mismatch on the held frame; qualified by rx_valid.
REQ-012 frame_err  out  1  a stop bit was sampled low on the held frame; qualified by rx_valid.
REQ-013 overrun  out  1  one-cycle pulse when a completed frame is dropped.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-015 RX shall pass through a 2-flop synchronizer (reset value 1) before any use; all timing below is relative to the synchronized signal.
REQ-016 The FSM shall have states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-017 IDLE -> START on a synchronized falling edge (previous 1, current 0); the bit counter clears to 0.
REQ-018 In START the bit counter shall count to (CLKS_PER_BIT-1)/2 and sample there: 0 -> DATA with counter cleared; 1 -> IDLE (glitch rejected, no output change).
REQ-019 DATA, PARITY and STOP shall each sample once, at counter value CLKS_PER_BIT-1, then clear the counter; this places every sample at mid-bit.
REQ-020 Data shall be sampled LSB first into a shift register; DATA exits after DATA_BITS samples.
REQ-021 Parity check: odd mode requires XOR(data, parity bit) = 1; even mode requires it = 0; a mismatch sets the internal parity flag.
REQ-022 STOP shall sample STOP_BITS bits; any low sample sets the internal frame flag; the frame completes at the last stop sample.
REQ-023 At completion the FSM shall return to IDLE in the same cycle, so a new start edge is detectable on the next cycle.
REQ-024 Completion with rx_valid=0, or with rx_valid=1 and rx_ready=1 in the same cycle: on the next clk edge load rx_data, parity_err and frame_err, and set rx_valid=1.
REQ-025 Completion with rx_valid=1 and rx_ready=0: keep the held frame unchanged and pulse overrun for one cycle.
REQ-026 rx_valid shall clear one cycle after rx_ready and rx_valid are both high (unless REQ-024 reloads it); rx_data shall stay stable while rx_valid is high.
REQ-027 A frame with parity or frame errors shall still be delivered, with the flags set.
REQ-028 Latency: rx_valid rises 1 clk after the final stop-bit sample cycle.
REQ-029 Bit and frame counters shall be sized with $clog2 of their maximum values; no counter may wrap within a frame.

Reset
REQ-030 While reset_p is high: FSM in IDLE; counters 0; synchronizer at 1; rx_data 0; rx_valid, parity_err, frame_err, overrun and busy all 0.
REQ-031 Reset asserted mid-frame shall discard the partial frame; after release, the first falling edge starts a fresh frame.

Structure
REQ-032 A shared package (uart_pkg) shall hold the FSM state typedef and the parity-mode constants PAR_NONE, PAR_ODD and PAR_EVEN.
REQ-033 One sub-module, uart_sync2 (the 2-flop synchronizer), shall be used; everything else shall be flat.

Verification
REQ-034 CLKS_PER_BIT=16, 8N1, send 0x30, rx_ready=1 -> one rx_valid pulse with rx_data=0x30 and both error flags 0.
REQ-035 PARITY=2, send 0x31 with parity bit 0 (wrong) -> rx_data=0x31, parity_err=1; the same byte with parity bit 1 -> parity_err=0.
REQ-036 RX low for 5 cycles, then high (CLKS_PER_BIT=16) -> busy pulses, FSM returns to IDLE, rx_valid stays 0.
REQ-037 Send 0x35 with the stop bit driven low -> rx_valid=1 with frame_err=1; the next good frame (0x36) is received correctly.
REQ-038 rx_ready=0, send 0x32 then 0x33 -> rx_data stays 0x32 and overrun pulses once; raise rx_ready -> rx_valid drops after 1 cycle.
REQ-039 Assert reset_p during the data bit 4 sample, release, then send 0x34 -> only 0x34 is delivered.
